demux4_stream_v1: RTL and testbench
===================================

DEMUX4_STREAM_V1 -- requirements
Module: demux4_stream_v1

Interface
REQ-001 SHALL have parameter: width, default 32, bit width of each data word.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: in_data  input  width  word to route.
REQ-005 SHALL have port: in_valid  input  1  in_data/in_sel valid.
REQ-006 SHALL have port: in_sel  input  2  destination channel (0..3 maps to out1..out4).
REQ-007 SHALL have port: in_ready  output  1  module accepts the word this cycle.
REQ-008 SHALL have ports: out1, out2, out3, out4  output  width each  head word of each channel.
REQ-009 SHALL have port: out_valid  output  4  bit i set = channel i+1 holds a word.
REQ-010 SHALL have port: out_ready  input  4  bit i set = consumer of channel i+1 takes head word.

Function
REQ-011 SHALL hold one 2-entry FIFO per channel, with an occupancy count of 0..2.
REQ-012 SHALL drive in_ready combinationally as 1 when the FIFO selected by in_sel has count < 2, independent of in_valid and out_ready.
REQ-013 SHALL push in_data into FIFO[in_sel] on a clock edge where in_valid and in_ready are both 1 (accept).
REQ-014 SHALL pop the head of channel i on a clock edge where out_valid[i] and out_ready[i] are both 1.
REQ-015 SHALL drive out_valid[i] = (count[i] != 0), and drive out(i+1) from the FIFO head register.
REQ-016 SHALL give latency 1: a word accepted at edge N into an empty FIFO is visible on its outN with out_valid set after edge N.
REQ-017 SHALL preserve per-channel order; words sent to different channels are independent.
REQ-018 SHALL, on simultaneous push and pop to the same channel, leave the count unchanged, advance the head, and lose no data.
REQ-019 SHALL deassert in_ready for a full channel even if that channel is popping the same cycle; no fall-through.
REQ-020 SHALL let a full channel stall only inputs addressed to it; in_ready for other in_sel values is unaffected.
REQ-021 SHALL ignore in_sel and in_data when in_valid is 0.
REQ-022 SHALL keep out(i+1) holding its last head value when out_valid[i] is 0; consumers must not rely on that value.
REQ-023 SHALL wrap FIFO read/write pointers modulo 2.

Reset
REQ-024 SHALL, while rst is high, asynchronously force all counts to 0, all pointers to 0, out_valid to 4'b0000, out1..out4 to 0.
REQ-025 SHALL discard all buffered words when rst asserts mid-operation, with no pop or push completing on that edge.
REQ-026 SHALL have in_ready = 1 for every in_sel from the first cycle after rst deasserts.

Configuration
REQ-027 SHALL, when macro DEMUX4_STREAM_V1_STATS_EN is defined, add ports stat_sel (input, 2) and stat_count (output, 16).
REQ-028 SHALL, with the macro defined, keep one 16-bit counter per channel that increments on each accept to that channel, saturates at 16'hFFFF, and resets to 0.
REQ-029 SHALL, with the macro defined, drive stat_count combinationally as the counter selected by stat_sel.
REQ-030 SHALL, without the macro, omit the stat_sel/stat_count ports and counters, with identical datapath behaviour.

Verification
REQ-031 SHALL cover basic routing: after reset, in_sel=2, in_data=32'hA5A5_0001, in_valid=1 for one cycle, out_ready=0 -> next cycle out_valid=4'b0100, out3=32'hA5A5_0001, in_ready=1.
REQ-032 SHALL cover full channel: push 3 words to channel 0 with out_ready=0 -> 2 accepted, in_ready=0 for in_sel=0 and 1 for in_sel=1; third word accepted only after one pop.
REQ-033 SHALL cover simultaneous push/pop: channel 1 holds 1 word, push 32'h2 while out_ready[1]=1 -> count stays 1, out2=32'h2 next cycle.
REQ-034 SHALL cover order and isolation: interleave 4 words to channels 0 and 3 with random out_ready -> each channel outputs its words in send order; a stall on channel 0 never blocks channel 3.
REQ-035 SHALL cover reset mid-operation: assert rst asynchronously with all channels full -> out_valid=0 and out1..out4=0 immediately, before the next clk edge.
REQ-036 SHALL cover counter saturation, with DEMUX4_STREAM_V1_STATS_EN defined: 65,540 accepts to channel 2, stat_sel=2 -> stat_count=16'hFFFF.

Source files
------------

// File: rtl/demux4_stream_v1.sv
// Purpose: routes one input stream to four output channels, each buffered by a 2-entry FIFO.
// Latency: 1 cycle from accept into an empty channel to that word appearing on its output.
// Backpressure: in_ready drops only when the channel addressed by in_sel is full; no fall-through.
// Optional: define DEMUX4_STREAM_V1_STATS_EN to add per-channel saturating accept counters.
module demux4_stream_v1 #(
  parameter int width = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [width-1:0] in_data,
  input  logic             in_valid,
  input  logic [1:0]       in_sel,
  output logic             in_ready,
  output logic [width-1:0] out1,
  output logic [width-1:0] out2,
  output logic [width-1:0] out3,
  output logic [width-1:0] out4,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready
`ifdef DEMUX4_STREAM_V1_STATS_EN
  ,
  input  logic [1:0]       stat_sel,
  output logic [15:0]      stat_count
`endif
);

  // Per-channel storage: two slots, pointers, occupancy and a registered head word.
  logic [width-1:0] mem  [4][2];
  logic [width-1:0] head [4];
  logic [1:0]       cnt  [4];
  logic             wptr [4];
  logic             rptr [4];
  logic [3:0]       push;
  logic [3:0]       pop;

  // Accept/pop decode; in_ready depends only on the addressed channel's occupancy.
  always_comb begin
    push     = '0;
    in_ready = (cnt[in_sel] != 2'd2);
    for (int i = 0; i < 4; i++) begin
      out_valid[i] = (cnt[i] != 2'd0);
    end
    if (in_valid && in_ready) begin
      push[in_sel] = 1'b1;
    end
    pop = out_valid & out_ready;
  end

  // FIFO state update; the head register follows whichever word is oldest.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        mem[i][0] <= '0;
        mem[i][1] <= '0;
        head[i]   <= '0;
        cnt[i]    <= 2'd0;
        wptr[i]   <= 1'b0;
        rptr[i]   <= 1'b0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (push[i]) begin
          mem[i][wptr[i]] <= in_data;
          wptr[i]         <= ~wptr[i];
        end
        if (pop[i]) begin
          rptr[i] <= ~rptr[i];
        end
        case ({push[i], pop[i]})
          2'b10:   cnt[i] <= cnt[i] + 2'd1;
          2'b01:   cnt[i] <= cnt[i] - 2'd1;
          default: cnt[i] <= cnt[i];
        endcase
        // New word becomes head when the channel is (or is about to be) otherwise empty;
        // popping a full channel promotes the second slot. Empty channels keep the last head.
        if (push[i] && ((cnt[i] == 2'd0) || ((cnt[i] == 2'd1) && pop[i]))) begin
          head[i] <= in_data;
        end else if (pop[i] && (cnt[i] == 2'd2)) begin
          head[i] <= mem[i][~rptr[i]];
        end
      end
    end
  end

  assign out1 = head[0];
  assign out2 = head[1];
  assign out3 = head[2];
  assign out4 = head[3];

`ifdef DEMUX4_STREAM_V1_STATS_EN
  logic [15:0] stat_cnt [4];

  // Saturating count of accepted words per channel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        stat_cnt[i] <= 16'd0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (push[i] && (stat_cnt[i] != 16'hFFFF)) begin
          stat_cnt[i] <= stat_cnt[i] + 16'd1;
        end
      end
    end
  end

  assign stat_count = stat_cnt[stat_sel];
`endif

endmodule

// File: tb/tb_demux4_stream_v1.sv
// Directed bench for demux4_stream_v1: routing, full channel, push/pop, isolation, async reset.
// Inputs change 1 time unit after the rising edge; outputs are sampled there as well.
// Stats counter saturation is exercised when DEMUX4_STREAM_V1_STATS_EN is defined.
module tb_demux4_stream_v1;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] in_data;
  logic         in_valid;
  logic [1:0]   in_sel;
  logic         in_ready;
  logic [W-1:0] out1, out2, out3, out4;
  logic [3:0]   out_valid;
  logic [3:0]   out_ready;
`ifdef DEMUX4_STREAM_V1_STATS_EN
  logic [1:0]   stat_sel;
  logic [15:0]  stat_count;
`endif

  int checks = 0;
  int errors = 0;

  demux4_stream_v1 #(.width(W)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_sel(in_sel),
    .in_ready(in_ready), .out1(out1), .out2(out2), .out3(out3), .out4(out4),
    .out_valid(out_valid), .out_ready(out_ready)
`ifdef DEMUX4_STREAM_V1_STATS_EN
    , .stat_sel(stat_sel), .stat_count(stat_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] outc(input int c);
    case (c)
      0:       return out1;
      1:       return out2;
      2:       return out3;
      default: return out4;
    endcase
  endfunction

  // Interleaved traffic for the order/isolation phase.
  logic [1:0]   sel_tab  [8] = '{2'd0, 2'd3, 2'd0, 2'd3, 2'd3, 2'd3, 2'd0, 2'd0};
  logic [W-1:0] data_tab [8] = '{32'hA000_0000, 32'hD000_0001, 32'hA000_0002, 32'hD000_0003,
                                 32'hD000_0004, 32'hD000_0005, 32'hA000_0006, 32'hA000_0007};
  logic [W-1:0] q0[$];
  logic [W-1:0] q3[$];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int idx;
    int popped;
    logic b0, b3, acc, exp_rdy;

    rst = 1'b1; in_valid = 1'b0; in_sel = 2'd0; in_data = '0; out_ready = 4'b0;
`ifdef DEMUX4_STREAM_V1_STATS_EN
    stat_sel = 2'd0;
`endif
    #12;
    check("rst_out_valid", out_valid, 4'b0000);
    for (int c = 0; c < 4; c++) check($sformatf("rst_out%0d", c + 1), outc(c), 32'h0);
    @(negedge clk); rst = 1'b0;
    for (int s = 0; s < 4; s++) begin
      in_sel = 2'(s); #1;
      check($sformatf("post_rst_rdy%0d", s), in_ready, 1'b1);
    end

    // Basic routing to channel 3 (in_sel=2).
    step();
    in_sel = 2'd2; in_data = 32'hA5A5_0001; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check("route_valid", out_valid, 4'b0100);
    check("route_out3", out3, 32'hA5A5_0001);
    check("route_rdy", in_ready, 1'b1);
    // Idle input must not push anything.
    in_sel = 2'd0; in_data = 32'hDEAD_BEEF;
    step();
    check("idle_valid", out_valid, 4'b0100);
    out_ready = 4'b0100;
    step();
    out_ready = 4'b0000;
    check("drain_valid", out_valid, 4'b0000);
    check("drain_hold", out3, 32'hA5A5_0001);

    // Full channel 0: third word held off until one pop.
    in_sel = 2'd0; in_valid = 1'b1; in_data = 32'h10;
    step();
    in_data = 32'h11;
    step();
    in_data = 32'h12; #1;
    check("full_rdy0", in_ready, 1'b0);
    in_sel = 2'd1; #1;
    check("full_rdy1", in_ready, 1'b1);
    in_sel = 2'd0;
    step();
    check("full_head", out1, 32'h10);
    check("full_valid", out_valid, 4'b0001);
    out_ready = 4'b0001; #1;
    check("full_no_fallthru", in_ready, 1'b0);
    step();
    out_ready = 4'b0000;
    check("full_pop_head", out1, 32'h11);
    check("full_pop_rdy", in_ready, 1'b1);
    step();
    in_valid = 1'b0;
    check("full_again_rdy", in_ready, 1'b0);
    out_ready = 4'b0001;
    step();
    check("full_third_head", out1, 32'h12);
    check("full_third_valid", out_valid, 4'b0001);
    step();
    out_ready = 4'b0000;
    check("full_empty", out_valid, 4'b0000);

    // Simultaneous push/pop on channel 2 (in_sel=1).
    in_sel = 2'd1; in_data = 32'h1; in_valid = 1'b1;
    step();
    check("pp_first", out2, 32'h1);
    in_data = 32'h2; out_ready = 4'b0010;
    step();
    in_valid = 1'b0;
    check("pp_valid", out_valid, 4'b0010);
    check("pp_out2", out2, 32'h2);
    step();
    out_ready = 4'b0000;
    check("pp_count1", out_valid, 4'b0000);

    // Order and isolation between channels 1 and 4 with random consumers.
    idx = 0; popped = 0;
    for (int cyc = 0; cyc < 80 && (idx < 8 || q0.size() != 0 || q3.size() != 0); cyc++) begin
      in_valid = (idx < 8);
      if (idx < 8) begin
        in_sel = sel_tab[idx]; in_data = data_tab[idx];
      end
      b0 = 1'($urandom_range(0, 1));
      b3 = 1'($urandom_range(0, 1));
      out_ready = {b3, 2'b00, (cyc >= 12) ? b0 : 1'b0};
      #1;
      if (idx < 8) begin
        exp_rdy = (in_sel == 2'd0) ? (q0.size() < 2) : (q3.size() < 2);
        check("iso_rdy", in_ready, exp_rdy);
      end
      check("iso_v0", out_valid[0], q0.size() != 0);
      check("iso_v3", out_valid[3], q3.size() != 0);
      if (out_valid[0] && out_ready[0] && q0.size() != 0) begin
        check("order_ch1", out1, q0.pop_front()); popped++;
      end
      if (out_valid[3] && out_ready[3] && q3.size() != 0) begin
        check("order_ch4", out4, q3.pop_front()); popped++;
      end
      acc = in_valid && in_ready;
      if (acc) begin
        if (in_sel == 2'd0) q0.push_back(in_data);
        else q3.push_back(in_data);
      end
      step();
      if (acc) idx++;
    end
    in_valid = 1'b0; out_ready = 4'b0000;
    check("order_popped", popped, 8);

    // Fill every channel, then reset asynchronously mid-cycle.
    in_valid = 1'b1;
    for (int c = 0; c < 4; c++) begin
      for (int k = 0; k < 2; k++) begin
        in_sel = 2'(c); in_data = 32'hF000_0000 + 32'(c * 16 + k);
        step();
      end
    end
    in_valid = 1'b0;
    check("fill_valid", out_valid, 4'b1111);
    #2;
    rst = 1'b1;
    #1;
    check("arst_valid", out_valid, 4'b0000);
    for (int c = 0; c < 4; c++) check($sformatf("arst_out%0d", c + 1), outc(c), 32'h0);
    @(negedge clk); rst = 1'b0;
    for (int s = 0; s < 4; s++) begin
      in_sel = 2'(s); #1;
      check($sformatf("arst_rdy%0d", s), in_ready, 1'b1);
    end
    check("arst_after_valid", out_valid, 4'b0000);

`ifdef DEMUX4_STREAM_V1_STATS_EN
    step();
    stat_sel = 2'd2; #1;
    check("stat_zero", stat_count, 16'h0);
    in_sel = 2'd2; in_valid = 1'b1; out_ready = 4'b0100;
    repeat (3) step();
    check("stat_three", stat_count, 16'd3);
    stat_sel = 2'd0; #1;
    check("stat_other", stat_count, 16'd0);
    stat_sel = 2'd2;
    repeat (65537) step();
    in_valid = 1'b0; out_ready = 4'b0000;
    #1;
    check("stat_sat", stat_count, 16'hFFFF);
    stat_sel = 2'd1; #1;
    check("stat_ch2_zero", stat_count, 16'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
